dmem_port_arbiter: RTL

// Shares the single-port data RAM between the single-cycle core (requester 0) and the UART

---
 rtl/dmem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the core (zero-latency path) and the UART word port.
// Optional stall statistics counter is built only when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_mem_access,
    input  logic                 cpu_memwrite,
    input  logic [BIT_WIDTH-1:0] cpu_addr,
    input  logic [BIT_WIDTH-1:0] cpu_wdata,
    output logic [BIT_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 uart_req,
    input  logic                 uart_we,
    input  logic [BIT_WIDTH-1:0] uart_addr,
    input  logic [BIT_WIDTH-1:0] uart_wdata,
    output logic                 uart_ack,
    output logic [BIT_WIDTH-1:0] uart_rdata,
    output logic [BIT_WIDTH-1:0] ram_addr,
    output logic [BIT_WIDTH-1:0] ram_wdata,
    output logic                 ram_we,
    input  logic [BIT_WIDTH-1:0] ram_rdata,
    output logic [CNT_W-1:0]     stall_count
);

    typedef enum logic [1:0] {StIdle, StWait, StStall, StDone} state_e;

    localparam logic [CNT_W-1:0] MaxWaitC = CNT_W'(MAX_WAIT);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 uart_ack_q;
    logic                 cpu_stall_q;
    logic [BIT_WIDTH-1:0] uart_rdata_q;
    logic                 req_free;
    logic                 grant;

    assign req_free = uart_req & ~cpu_mem_access;
    assign grant    = (((state_q == StIdle) || (state_q == StWait)) & req_free)
                    | (state_q == StStall);

    assign cpu_rdata  = ram_rdata;
    assign cpu_stall  = cpu_stall_q;
    assign uart_ack   = uart_ack_q;
    assign uart_rdata = uart_rdata_q;
    assign ram_addr   = grant ? uart_addr  : cpu_addr;
    assign ram_wdata  = grant ? uart_wdata : cpu_wdata;
    assign ram_we     = grant ? uart_we    : (cpu_memwrite & ~cpu_stall_q);

    // Outputs are registered alongside the state so ack/stall track DONE/STALL exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            uart_ack_q   <= 1'b0;
            cpu_stall_q  <= 1'b0;
            uart_rdata_q <= '0;
        end else begin
            if (grant) begin
                uart_rdata_q <= ram_rdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_free) begin
                        state_q    <= StDone;
                        uart_ack_q <= 1'b1;
                    end else if (uart_req) begin
                        state_q <= StWait;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                StWait: begin
                    if (!uart_req) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (!cpu_mem_access) begin
                        state_q    <= StDone;
                        uart_ack_q <= 1'b1;
                    end else if (cnt_q == MaxWaitC) begin
                        state_q     <= StStall;
                        cpu_stall_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StStall: begin
                    state_q     <= StDone;
                    cpu_stall_q <= 1'b0;
                    uart_ack_q  <= 1'b1;
                end
                StDone: begin
                    state_q    <= StIdle;
                    uart_ack_q <= 1'b0;
                    cnt_q      <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_W-1:0] stall_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else if ((state_q == StStall) && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule
